// File: rtl/draw_pkg.sv
// Shared types for the VGA draw command sequencer.
// Opcodes, command bundle, FSM states and coordinate widths.
package draw_pkg;

  localparam int X_W = 8;
  localparam int Y_W = 7;

  typedef enum logic [1:0] {
    OP_FILL     = 2'd0,
    OP_CIRCLE   = 2'd1,
    OP_REULEAUX = 2'd2,
    OP_ILLEGAL  = 2'd3
  } op_e;

  typedef struct packed {
    op_e            op;
    logic [2:0]     colour;
    logic [X_W-1:0] cx;
    logic [Y_W-1:0] cy;
    logic [7:0]     size;
  } cmd_t;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_RUN     = 2'd1,
    S_RELEASE = 2'd2
  } state_e;

endpackage

// File: rtl/cmd_fifo.sv
// Small synchronous FIFO with registered full/empty flags.
// Push is refused while full even if a pop happens that cycle.
module cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 28
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr, rptr;
  logic [AW-1:0]    wptr_inc, rptr_inc;
  logic             do_push, do_pop;

  assign do_push  = push & ~full;
  assign do_pop   = pop & ~empty;
  assign wptr_inc = wptr + 1'b1;
  assign rptr_inc = rptr + 1'b1;
  assign rdata    = mem[rptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (do_push) begin
      mem[wptr] <= wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      full  <= 1'b0;
      empty <= 1'b1;
    end else begin
      if (do_push) wptr <= wptr_inc;
      if (do_pop)  rptr <= rptr_inc;
      unique case ({do_push, do_pop})
        2'b10: begin
          empty <= 1'b0;
          full  <= (wptr_inc == rptr);
        end
        2'b01: begin
          full  <= 1'b0;
          empty <= (rptr_inc == wptr);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/draw_sequencer.sv
// Queues draw commands and runs one engine at a time,
// muxing the active engine's pixels onto the VGA port.
module draw_sequencer
  import draw_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           cmd_valid,
  output logic           cmd_ready,
  input  logic [1:0]     cmd_op,
  input  logic [2:0]     cmd_colour,
  input  logic [X_W-1:0] cmd_cx,
  input  logic [Y_W-1:0] cmd_cy,
  input  logic [7:0]     cmd_size,
  output logic [2:0]     eng_colour,
  output logic [X_W-1:0] eng_cx,
  output logic [Y_W-1:0] eng_cy,
  output logic [7:0]     eng_size,
  output logic [2:0]     eng_start,
  input  logic [2:0]     eng_done,
  input  logic [2:0]     eng_plot,
  input  logic [23:0]    eng_x,
  input  logic [20:0]    eng_y,
  output logic [X_W-1:0] vga_x,
  output logic [Y_W-1:0] vga_y,
  output logic [2:0]     vga_colour,
  output logic           vga_plot,
  output logic           busy,
  output logic           err
);

  cmd_t   cmd_in, head;
  logic   fifo_full, fifo_empty, fifo_pop;
  state_e state_q, state_d;
  logic [1:0] sel_q;
  logic   latch, set_err;
  logic   done_sel, plot_sel, active;
  logic [X_W-1:0] x_sel;
  logic [Y_W-1:0] y_sel;

  assign cmd_in = {cmd_op, cmd_colour, cmd_cx, cmd_cy, cmd_size};

  cmd_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH ($bits(cmd_t))
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (cmd_valid),
    .pop   (fifo_pop),
    .wdata (cmd_in),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign cmd_ready = ~fifo_full;
  assign busy      = (state_q != S_IDLE) | ~fifo_empty;

  always_comb begin
    done_sel = 1'b0;
    plot_sel = 1'b0;
    x_sel    = '0;
    y_sel    = '0;
    unique case (sel_q)
      2'd0: begin
        done_sel = eng_done[0];
        plot_sel = eng_plot[0];
        x_sel    = eng_x[7:0];
        y_sel    = eng_y[6:0];
      end
      2'd1: begin
        done_sel = eng_done[1];
        plot_sel = eng_plot[1];
        x_sel    = eng_x[15:8];
        y_sel    = eng_y[13:7];
      end
      2'd2: begin
        done_sel = eng_done[2];
        plot_sel = eng_plot[2];
        x_sel    = eng_x[23:16];
        y_sel    = eng_y[20:14];
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    fifo_pop  = 1'b0;
    latch     = 1'b0;
    set_err   = 1'b0;
    eng_start = '0;
    unique case (state_q)
      S_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          if (head.op == OP_ILLEGAL) begin
            set_err = 1'b1;
          end else begin
            latch   = 1'b1;
            state_d = S_RUN;
          end
        end
      end
      S_RUN: begin
        eng_start = 3'b001 << sel_q;
        if (done_sel) state_d = S_RELEASE;
      end
      S_RELEASE: begin
        if (!done_sel) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      sel_q      <= '0;
      eng_colour <= '0;
      eng_cx     <= '0;
      eng_cy     <= '0;
      eng_size   <= '0;
      err        <= 1'b0;
    end else begin
      state_q <= state_d;
      if (latch) begin
        sel_q      <= head.op;
        eng_colour <= head.colour;
        eng_cx     <= head.cx;
        eng_cy     <= head.cy;
        eng_size   <= head.size;
      end
      if (set_err) err <= 1'b1;
    end
  end

  // RELEASE still forwards so a pixel landing with done is kept
  assign active     = (state_q == S_RUN) | (state_q == S_RELEASE);
  assign vga_plot   = active & plot_sel;
  assign vga_x      = active ? x_sel : '0;
  assign vga_y      = active ? y_sel : '0;
  assign vga_colour = eng_colour;

endmodule

// File: tb/tb_draw_sequencer.sv
// Randomised bench for draw_sequencer with engine models,
// an expected-command queue and a pixel scoreboard.
module tb_draw_sequencer;
  import draw_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [1:0]  cmd_op = '0;
  logic [2:0]  cmd_colour = '0;
  logic [7:0]  cmd_cx = '0;
  logic [6:0]  cmd_cy = '0;
  logic [7:0]  cmd_size = '0;
  logic [2:0]  eng_colour;
  logic [7:0]  eng_cx;
  logic [6:0]  eng_cy;
  logic [7:0]  eng_size;
  logic [2:0]  eng_start;
  logic [2:0]  eng_done = '0;
  logic [2:0]  eng_plot = '0;
  logic [23:0] eng_x = '0;
  logic [20:0] eng_y = '0;
  logic [7:0]  vga_x;
  logic [6:0]  vga_y;
  logic [2:0]  vga_colour;
  logic        vga_plot;
  logic        busy;
  logic        err;

  draw_sequencer #(.FIFO_DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_colour(cmd_colour),
    .cmd_cx(cmd_cx), .cmd_cy(cmd_cy), .cmd_size(cmd_size),
    .eng_colour(eng_colour), .eng_cx(eng_cx),
    .eng_cy(eng_cy), .eng_size(eng_size),
    .eng_start(eng_start), .eng_done(eng_done),
    .eng_plot(eng_plot), .eng_x(eng_x), .eng_y(eng_y),
    .vga_x(vga_x), .vga_y(vga_y),
    .vga_colour(vga_colour), .vga_plot(vga_plot),
    .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] x;
    logic [6:0] y;
  } pix_t;

  int   total = 0;
  int   bad = 0;
  int   dur[3], npix[3], hold[3];
  int   cnt[3], holdc[3];
  bit   act[3];
  bit   rogue = 0;
  bit   mon_en = 0;
  bit   exp_err = 0;
  cmd_t exp_q[$];
  pix_t pix_q[$];
  int   start_cnt = 0, plot_cnt = 0;
  int   gap = 0, last_gap = 0;
  logic [2:0] prev_start = '0, prev_done = '0;
  cmd_t cur;

  // Engine behaviour: after start, run dur cycles, plot in the
  // last npix of them (incl. the done cycle), hold done hold
  // extra cycles once start has fallen.
  always @(posedge clk) begin
    #1;
    for (int i = 0; i < 3; i++) begin
      if (!rst_n) begin
        act[i] = 0;
        eng_done[i] = 1'b0;
        eng_plot[i] = 1'b0;
      end else begin
        eng_plot[i] = 1'b0;
        if (!act[i] && !eng_done[i] && eng_start[i]) begin
          act[i] = 1;
          cnt[i] = 0;
        end
        if (act[i]) begin
          cnt[i]++;
          if (cnt[i] > dur[i] - npix[i]) begin
            pix_t p;
            p.x = 8'(i * 40 + 10 + cnt[i]);
            p.y = 7'(cnt[i] + i);
            eng_plot[i] = 1'b1;
            eng_x[i*8 +: 8] = p.x;
            eng_y[i*7 +: 7] = p.y;
            pix_q.push_back(p);
          end
          if (cnt[i] >= dur[i]) begin
            eng_done[i] = 1'b1;
            act[i] = 0;
            holdc[i] = hold[i];
          end
        end else if (eng_done[i] && !eng_start[i]) begin
          if (holdc[i] == 0) eng_done[i] = 1'b0;
          else holdc[i]--;
        end
        if (rogue && i < 2 && !act[i]) begin
          eng_plot[i] = 1'b1;
          eng_x[i*8 +: 8] = 8'd5;
          eng_y[i*7 +: 7] = 7'd5;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (mon_en && rst_n) begin
      total++;
      if (vga_colour !== eng_colour) begin
        bad++;
        $display("FAIL colour_pass got=%0d want=%0d",
                 vga_colour, eng_colour);
      end
      if (eng_start != 0 && prev_start == 0) begin
        logic [2:0] one;
        start_cnt++;
        last_gap = gap;
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_start got=%b want=000",
                   eng_start);
        end else begin
          cur = exp_q.pop_front();
          one = 3'b001 << cur.op;
          if ({eng_start, eng_colour, eng_cx, eng_cy, eng_size} !==
              {one, cur.colour, cur.cx, cur.cy, cur.size}) begin
            bad++;
            $display("FAIL start_cmd got=%b/%0d/%0d/%0d/%0d want=%b/%0d/%0d/%0d/%0d",
                     eng_start, eng_colour, eng_cx, eng_cy, eng_size,
                     one, cur.colour, cur.cx, cur.cy, cur.size);
          end
        end
      end else if (eng_start != 0) begin
        total++;
        if ({eng_start, eng_colour, eng_cx, eng_cy, eng_size} !==
            {prev_start, cur.colour, cur.cx, cur.cy, cur.size}) begin
          bad++;
          $display("FAIL run_stable got=%b/%0d/%0d want=%b/%0d/%0d",
                   eng_start, eng_cx, eng_size,
                   prev_start, cur.cx, cur.size);
        end
      end
      if ((prev_start & prev_done) != 0) begin
        total++;
        if (eng_start !== 3'b000) begin
          bad++;
          $display("FAIL start_after_done got=%b want=000", eng_start);
        end
      end
      gap = (eng_start == 0) ? gap + 1 : 0;
      if (vga_plot) begin
        plot_cnt++;
        total++;
        if (pix_q.size() == 0) begin
          bad++;
          $display("FAIL spurious_pixel got=%0d,%0d want=none",
                   vga_x, vga_y);
        end else begin
          pix_t p;
          p = pix_q.pop_front();
          if (vga_x !== p.x || vga_y !== p.y) begin
            bad++;
            $display("FAIL pixel got=%0d,%0d want=%0d,%0d",
                     vga_x, vga_y, p.x, p.y);
          end
        end
      end else if (!busy) begin
        total++;
        if (vga_x !== 8'd0 || vga_y !== 7'd0) begin
          bad++;
          $display("FAIL idle_coords got=%0d,%0d want=0,0",
                   vga_x, vga_y);
        end
      end
      prev_start = eng_start;
      prev_done = eng_done;
    end
  end

  function automatic cmd_t mk(input int op, input int col,
                              input int cx, input int cy,
                              input int sz);
    cmd_t c;
    c.op = op_e'(op);
    c.colour = 3'(col);
    c.cx = 8'(cx);
    c.cy = 7'(cy);
    c.size = 8'(sz);
    return c;
  endfunction

  task automatic send(input cmd_t c, output int waited);
    waited = 0;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_op = c.op;
    cmd_colour = c.colour;
    cmd_cx = c.cx;
    cmd_cy = c.cy;
    cmd_size = c.size;
    while (!cmd_ready && waited < 3000) begin
      @(negedge clk);
      waited++;
    end
    total++;
    if (!cmd_ready) begin
      bad++;
      $display("FAIL send_timeout got=ready0 want=ready1");
    end
    if (c.op == OP_ILLEGAL) exp_err = 1;
    else exp_q.push_back(c);
  endtask

  task automatic drop();
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
  endtask

  task automatic set_engines(input int d, input int n, input int h);
    for (int i = 0; i < 3; i++) begin
      dur[i] = d;
      npix[i] = n;
      hold[i] = h;
    end
  endtask

  task automatic wait_idle(input string tag);
    int t = 0;
    int quiet = 0;
    while (quiet < 3 && t < 5000) begin
      @(negedge clk);
      t++;
      if (!busy && eng_done == 0 && !act[0] && !act[1] && !act[2])
        quiet++;
      else
        quiet = 0;
    end
    total++;
    if (quiet < 3) begin
      bad++;
      $display("FAIL %s_idle_timeout got=busy%0d want=busy0",
               tag, busy);
    end
    total++;
    if (exp_q.size() != 0 || pix_q.size() != 0) begin
      bad++;
      $display("FAIL %s_leftover got=cmds%0d,pix%0d want=0,0",
               tag, exp_q.size(), pix_q.size());
    end
    total++;
    if (err !== exp_err) begin
      bad++;
      $display("FAIL %s_err got=%b want=%b", tag, err, exp_err);
    end
  endtask

  task automatic wait_done(input int i, input string tag);
    int t = 0;
    while (!eng_done[i] && t < 3000) begin
      @(negedge clk);
      t++;
    end
    total++;
    if (!eng_done[i]) begin
      bad++;
      $display("FAIL %s_done_timeout got=0 want=1", tag);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    set_engines(4, 1, 0);
    repeat (3) @(negedge clk);
    total++;
    if ({cmd_ready, eng_start, busy, err, vga_plot} !== 7'b1000000) begin
      bad++;
      $display("FAIL reset_ctrl got=%b want=1000000",
               {cmd_ready, eng_start, busy, err, vga_plot});
    end
    total++;
    if ({eng_colour, eng_cx, eng_cy, eng_size, vga_x, vga_y,
         vga_colour} !== '0) begin
      bad++;
      $display("FAIL reset_data got=%0d/%0d/%0d/%0d/%0d want=0",
               eng_colour, eng_cx, eng_cy, eng_size, vga_x);
    end
    rst_n = 1'b1;
    @(negedge clk);
    prev_start = '0;
    prev_done = '0;
    mon_en = 1;
  endtask

  task automatic test_circle();
    int w;
    int pc0 = plot_cnt;
    dur[1] = 8;
    npix[1] = 5;
    hold[1] = 0;
    send(mk(1, 2, 80, 60, 30), w);
    drop();
    total++;
    if (eng_start !== 3'b000) begin
      bad++;
      $display("FAIL circle_early got=%b want=000", eng_start);
    end
    @(posedge clk);
    #1;
    total++;
    if ({eng_start, eng_cx, eng_cy, eng_size, eng_colour} !==
        {3'b010, 8'd80, 7'd60, 8'd30, 3'd2}) begin
      bad++;
      $display("FAIL circle_start got=%b/%0d/%0d/%0d/%0d want=010/80/60/30/2",
               eng_start, eng_cx, eng_cy, eng_size, eng_colour);
    end
    wait_done(1, "circle");
    @(negedge clk);
    total++;
    if (eng_start !== 3'b000) begin
      bad++;
      $display("FAIL circle_stop got=%b want=000", eng_start);
    end
    @(negedge clk);
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL circle_busy got=%b want=0", busy);
    end
    wait_idle("circle");
    total++;
    if (plot_cnt - pc0 != 5) begin
      bad++;
      $display("FAIL circle_pixels got=%0d want=5", plot_cnt - pc0);
    end
  endtask

  task automatic test_back_to_back();
    int ops[6] = '{0, 2, 1, 0, 1, 2};
    int w;
    int stall_at = -1;
    int sc0 = start_cnt;
    set_engines(20, 3, 0);
    for (int k = 0; k < 6; k++) begin
      send(mk(ops[k], $urandom_range(0, 7), $urandom_range(0, 255),
              $urandom_range(0, 127), $urandom_range(0, 255)), w);
      if (w > 0 && stall_at < 0) stall_at = k;
    end
    drop();
    total++;
    if (stall_at != 5) begin
      bad++;
      $display("FAIL b2b_ready got=%0d want=5", stall_at);
    end
    wait_idle("b2b");
    total++;
    if (start_cnt - sc0 != 6 || last_gap != 2) begin
      bad++;
      $display("FAIL b2b_runs got=%0d,gap%0d want=6,gap2",
               start_cnt - sc0, last_gap);
    end
  endtask

  task automatic test_illegal();
    int w;
    int sc0 = start_cnt;
    set_engines(6, 2, 0);
    send(mk(0, 1, 10, 10, 0), w);
    send(mk(3, 7, 99, 99, 99), w);
    send(mk(0, 4, 20, 20, 0), w);
    drop();
    wait_idle("illegal");
    repeat (5) @(negedge clk);
    total++;
    if (err !== 1'b1 || start_cnt - sc0 != 2) begin
      bad++;
      $display("FAIL illegal_sticky got=err%b,runs%0d want=err1,runs2",
               err, start_cnt - sc0);
    end
  endtask

  task automatic test_ignore_others();
    int w;
    int t = 0;
    dur[2] = 15;
    npix[2] = 10;
    hold[2] = 0;
    send(mk(2, 5, 40, 30, 50), w);
    drop();
    while (!eng_start[2] && t < 100) begin
      @(negedge clk);
      t++;
    end
    rogue = 1;
    while (!eng_done[2] && t < 200) begin
      @(negedge clk);
      t++;
      total++;
      if (vga_plot !== eng_plot[2] || (vga_plot && vga_x == 8'd5)) begin
        bad++;
        $display("FAIL rogue_mux got=%b,x%0d want=%b",
                 vga_plot, vga_x, eng_plot[2]);
      end
    end
    rogue = 0;
    wait_idle("rogue");
  endtask

  task automatic test_reset_mid();
    int w;
    int t = 0;
    int sc;
    set_engines(30, 2, 0);
    send(mk(3, 0, 0, 0, 0), w);
    send(mk(0, 1, 1, 1, 0), w);
    send(mk(1, 2, 2, 2, 9), w);
    send(mk(2, 3, 3, 3, 9), w);
    drop();
    while (eng_start == 0 && t < 100) begin
      @(negedge clk);
      t++;
    end
    @(posedge clk);
    #3;
    mon_en = 0;
    rst_n = 1'b0;
    exp_q.delete();
    pix_q.delete();
    exp_err = 0;
    #1;
    total++;
    if ({eng_start, cmd_ready, busy, err} !== 6'b000100) begin
      bad++;
      $display("FAIL midreset got=%b want=000100",
               {eng_start, cmd_ready, busy, err});
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    prev_start = '0;
    prev_done = '0;
    sc = start_cnt;
    mon_en = 1;
    repeat (60) @(negedge clk);
    total++;
    if (start_cnt != sc || busy !== 1'b0) begin
      bad++;
      $display("FAIL midreset_quiet got=runs%0d,busy%b want=0,0",
               start_cnt - sc, busy);
    end
    wait_idle("midreset");
  endtask

  task automatic test_done_hold();
    int w;
    set_engines(6, 2, 0);
    hold[0] = 10;
    send(mk(0, 6, 7, 8, 0), w);
    send(mk(0, 3, 9, 4, 0), w);
    drop();
    wait_idle("hold");
    total++;
    if (last_gap != 12) begin
      bad++;
      $display("FAIL hold_gap got=%0d want=12", last_gap);
    end
    hold[0] = 0;
  endtask

  task automatic test_random();
    for (int b = 0; b < 3; b++) begin
      int legal = 0;
      int sc0 = start_cnt;
      int w;
      for (int i = 0; i < 3; i++) begin
        dur[i] = $urandom_range(4, 25);
        npix[i] = $urandom_range(1, dur[i]);
        hold[i] = $urandom_range(0, 4);
      end
      for (int k = 0; k < 8; k++) begin
        cmd_t c;
        c = mk($urandom_range(0, 3), $urandom, $urandom,
               $urandom, $urandom);
        if (c.op != OP_ILLEGAL) legal++;
        send(c, w);
        if ($urandom_range(0, 2) == 0) begin
          drop();
          repeat ($urandom_range(0, 30)) @(negedge clk);
        end
      end
      drop();
      wait_idle("random");
      total++;
      if (start_cnt - sc0 != legal) begin
        bad++;
        $display("FAIL random_runs got=%0d want=%0d",
                 start_cnt - sc0, legal);
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got=running want=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_circle();
    test_back_to_back();
    test_illegal();
    test_ignore_others();
    test_done_hold();
    test_random();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/draw_sequencer.md
Name:
draw_sequencer

Overview:
- Command scheduler for the VGA drawing engines: fill-screen (engine 0), circle (engine 1) and Reuleaux triangle (engine 2).
- Accepts draw commands over a valid/ready port into a small FIFO.
- Runs one command at a time: sets up the shared shape parameters, drives the selected engine through the start/done protocol, and muxes that engine's pixel stream onto the single VGA adapter write port.

Parameters:
FIFO_DEPTH, 4, command FIFO entries; power of two, >= 2.

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
cmd_valid  in  1  command offered
cmd_ready  out  1  FIFO can accept (= !full)
cmd_op  in  2  0 FILL, 1 CIRCLE, 2 REULEAUX, 3 illegal
cmd_colour  in  3  draw colour
cmd_cx  in  8  centre x
cmd_cy  in  7  centre y
cmd_size  in  8  radius (CIRCLE) or diameter (REULEAUX); ignored by FILL
eng_colour  out  3  latched colour to all engines
eng_cx  out  8  latched centre x to all engines
eng_cy  out  7  latched centre y to all engines
eng_size  out  8  latched size to all engines
eng_start  out  3  one-hot start, bit i = engine i
eng_done  in  3  engine done flags
eng_plot  in  3  engine plot strobes
eng_x  in  24  packed {e2_x, e1_x, e0_x}, 8 bits each
eng_y  in  21  packed {e2_y, e1_y, e0_y}, 7 bits each
vga_x  out  8  to VGA adapter
vga_y  out  7  to VGA adapter
vga_colour  out  3  to VGA adapter
vga_plot  out  1  to VGA adapter write strobe
busy  out  1  FSM not IDLE, or FIFO non-empty
err  out  1  sticky: illegal opcode popped

Behaviour:
Reset values:
- All outputs 0, except cmd_ready = 1.
- FIFO empty; state IDLE; err cleared.
- Reset mid-operation aborts the running command and discards queued commands.

FIFO:
- Push on cmd_valid & cmd_ready; cmd_ready is computed from the registered full flag only.
- When full, a same-cycle pop does not allow a push.
- A pushed entry is visible to the FSM on the cycle after its push edge.
- Pointers wrap modulo FIFO_DEPTH.

FSM, states IDLE, RUN, RELEASE:
- IDLE, FIFO non-empty: pop the head.
  - Opcode 0..2: latch colour/cx/cy/size into eng_* and sel = op, then go to RUN.
  - Opcode 3: set err, stay IDLE; no start is issued.
- RUN:
  - eng_start[sel] = 1; all other start bits 0.
  - eng_* held stable throughout.
  - Go to RELEASE on the first cycle eng_done[sel] = 1.
- RELEASE:
  - All starts 0.
  - Return to IDLE when eng_done[sel] = 0.
  - Engines are required to clear done once start falls; the sequencer waits indefinitely otherwise.

Latency:
- Command accepted at edge E, FIFO previously empty and FSM idle: eng_start[sel] high after edge E+1.
- Minimum command-to-command turnaround is 3 cycles after done (RUN -> RELEASE -> IDLE -> RUN).

Pixel mux (combinational, zero latency):
- In RUN: vga_x/vga_y/vga_plot = engine sel's fields.
- In RELEASE: the same fields, so the final pixel is not lost.
- Otherwise vga_plot = 0 and vga_x = vga_y = 0.
- vga_colour = eng_colour at all times.
- Plot strobes from non-selected engines are ignored.
- A pixel arriving in the same cycle as done is forwarded.

Other rules:
- No arithmetic on coordinates; widths pass through unchanged.
- eng_done bits of non-selected engines are ignored.

Decomposition:
- Shared package draw_pkg:
  - op enum (OP_FILL = 0, OP_CIRCLE = 1, OP_REULEAUX = 2, OP_ILLEGAL = 3).
  - Packed cmd struct {op, colour, cx, cy, size} = 28 bits.
  - State enum; X_W = 8 and Y_W = 7.
- Sub-module cmd_fifo:
  - Parameterised by depth and width; registered full/empty flags; async active-low reset.
  - The FSM and pixel mux stay in draw_sequencer.

Test Plan:
- Single CIRCLE (colour 3'b010, cx 80, cy 60, size 30) pushed when idle:
  - eng_start = 3'b010 after edge E+1; eng_cx = 80, eng_cy = 60, eng_size = 30.
  - Engine model plots 5 pixels then done: vga_plot pulses 5 times with e1 coordinates and vga_colour = 2.
  - start drops the cycle after done; busy = 0 after done falls.
- cmd_valid held for 6 back-to-back commands (FILL, REULEAUX, CIRCLE, FILL, CIRCLE, REULEAUX) against engines taking 20 cycles:
  - cmd_ready low after 4 are accepted, or 5 once the first is popped.
  - All 6 execute in order, with start one-hot sequence 001, 100, 010, 001, 010, 100.
- Opcode 3 queued between two FILLs:
  - err = 1 and stays 1; no start is issued for the illegal command.
  - Both FILLs still run.
- During a REULEAUX run, engines 0 and 1 assert plot with x = 5:
  - vga_plot follows only eng_plot[2]; vga_x never shows 5 from the others.
- rst_n pulsed low mid-RUN with 2 commands queued:
  - eng_start = 0, cmd_ready = 1, busy = 0 and err = 0 immediately.
  - Nothing further executes after release.
- Engine holds done high for 10 cycles after start falls:
  - FSM stays in RELEASE for 10 cycles; the next start is delayed until done = 0.
